// File: rtl/data_ram_unit_pkg.sv
// Shared definitions for the data RAM: access-size encoding and byte-lane mask helper.
package data_ram_unit_pkg;

   typedef enum logic [1:0] {
      SZ_WORD = 2'd0,
      SZ_HALF = 2'd1,
      SZ_BYTE = 2'd2
   } size_e;

   // Byte lanes touched by an access of size sz at byte offset off (little-endian).
   function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] off);
      logic [3:0] mask;
      case (sz)
         SZ_WORD: mask = 4'b1111;
         SZ_HALF: mask = off[1] ? 4'b1100 : 4'b0011;
         SZ_BYTE: mask = 4'b0001 << off;
         default: mask = 4'b0000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/data_ram_unit_load_ext.sv
// Load path: selects the addressed lane(s) of a memory word and sign/zero extends them.
module data_ram_load_ext
   import data_ram_unit_pkg::*;
(
   input  logic [31:0] word,
   input  size_e       size,
   input  logic [1:0]  off,
   input  logic        z,
   output logic [31:0] data
);

   logic [15:0] half_lane;
   logic [7:0]  byte_lane;

   // Lane select followed by extension; word accesses pass straight through.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
      data      = word;
      half_lane = off[1] ? word[31:16] : word[15:0];
      byte_lane = word[8*off +: 8];
      case (size)
         SZ_HALF: data = z ? {16'h0000, half_lane} : {{16{half_lane[15]}}, half_lane};
         SZ_BYTE: data = z ? {24'h000000, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/data_ram_unit.sv
// Byte-addressable data memory with word/half/byte stores, extended loads and access-error flag.
module data_ram_unit
   import data_ram_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int BYTE_BITS  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ram_ena,
   input  logic        wena,
   input  logic        w,
   input  logic        h,
   input  logic        b,
   input  logic        z,
   input  logic [19:0] addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        AddressError
);

   localparam int IDX_W = ADDR_WIDTH - BYTE_BITS;
   localparam int DEPTH = 2 ** IDX_W;

   logic [31:0]      mem_q [0:DEPTH-1];
   size_e            size;
   logic [1:0]       off;
   logic [IDX_W-1:0] idx;
   logic [3:0]       wr_be_d;
   logic [31:0]      wr_data_d;
   logic [31:0]      ld_data;

   assign off = addr[1:0];
   assign idx = addr[ADDR_WIDTH-1:BYTE_BITS];

   // Size decode with priority w > h > b; no select bit means a word access.
   always_comb begin
      size = SZ_WORD;
      if (w)      size = SZ_WORD;
      else if (h) size = SZ_HALF;
      else if (b) size = SZ_BYTE;
   end

   // Access error: address beyond capacity (no wrap) or misaligned for its size.
   always_comb begin
      AddressError = 1'b0;
      if (ram_ena) begin
         AddressError = (addr[19:ADDR_WIDTH] != '0)
                      | ((size == SZ_WORD) & (off != 2'b00))
                      | ((size == SZ_HALF) & off[0]);
      end
   end

   // Store lanes and right-justified store data replicated onto every lane position.
   always_comb begin
      wr_be_d   = 4'b0000;
      wr_data_d = data_in;
      if (ram_ena && wena && !AddressError) wr_be_d = lane_mask(size, off);
      case (size)
         SZ_HALF: wr_data_d = {2{data_in[15:0]}};
         SZ_BYTE: wr_data_d = {4{data_in[7:0]}};
         default: wr_data_d = data_in;
      endcase
   end

   // Memory array: synchronous clear has priority over a store; only enabled lanes change.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: clearing the whole array is architecturally visible (loads after reset must return 0), so this memory is reset, unlike a plain RAM macro.
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            if (wr_be_d[k]) mem_q[idx][8*k +: 8] <= wr_data_d[8*k +: 8];
         end
      end
   end

   data_ram_load_ext u_load_ext (
      .word (mem_q[idx]),
      .size (size),
      .off  (off),
      .z    (z),
      .data (ld_data)
   );

   // Load data is visible only for a legal, enabled read.
   always_comb begin
      data_out = 32'h0000_0000;
      if (ram_ena && !wena && !AddressError) data_out = ld_data;
   end

endmodule

// File: tb/tb_data_ram_unit.sv
// Self-checking bench for data_ram_unit: directed scenarios plus randomized traffic vs a byte-array model.
module tb_data_ram_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ram_ena = 1'b0;
   logic        wena = 1'b0;
   logic        w = 1'b0;
   logic        h = 1'b0;
   logic        b = 1'b0;
   logic        z = 1'b0;
   logic [19:0] addr = '0;
   logic [31:0] data_in = '0;
   logic [31:0] data_out;
   logic        AddressError;

   int checks = 0;
   int errors = 0;

   logic [31:0] dout_s;
   logic        err_s;
   logic [7:0]  ref_mem [0:1023];

   data_ram_unit dut (
      .clk          (clk),
      .rst          (rst),
      .ram_ena      (ram_ena),
      .wena         (wena),
      .w            (w),
      .h            (h),
      .b            (b),
      .z            (z),
      .addr         (addr),
      .data_in      (data_in),
      .data_out     (data_out),
      .AddressError (AddressError)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int model_size(input logic iw, input logic ih, input logic ib);
      if (iw) return 4;
      if (ih) return 2;
      if (ib) return 1;
      return 4;
   endfunction

   function automatic logic model_err(input logic en, input int sz, input logic [19:0] a);
      if (!en) return 1'b0;
      return (int'(a) >= 1024) || ((int'(a) % sz) != 0);
   endfunction

   function automatic logic [31:0] model_load(input int sz, input logic [19:0] a, input logic iz);
      logic [31:0] v;
      v = 32'h0;
      for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8 * i));
      if (sz < 4 && !iz && v[8*sz-1]) v = v | (32'hffff_ffff << (8 * sz));
      return v;
   endfunction

   // Drive one cycle of inputs away from the rising edge, sample outputs, then
   // apply to the model whatever the coming edge will do to memory.
   task automatic op(input logic r, input logic en, input logic we,
                     input logic iw, input logic ih, input logic ib, input logic iz,
                     input logic [19:0] a, input logic [31:0] d);
      int sz;
      @(negedge clk);
      rst = r; ram_ena = en; wena = we; w = iw; h = ih; b = ib; z = iz;
      addr = a; data_in = d;
      #1;
      dout_s = data_out;
      err_s  = AddressError;
      sz = model_size(iw, ih, ib);
      if (r) begin
         for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
      end else if (en && we && !model_err(en, sz, a)) begin
         for (int i = 0; i < sz; i++) ref_mem[int'(a) + i] = d[8*i +: 8];
      end
   endtask

   // Shorthands: word/half/byte loads and stores with no reset.
   task automatic ld(input int sz, input logic iz, input logic [19:0] a);
      op(1'b0, 1'b1, 1'b0, sz == 4, sz == 2, sz == 1, iz, a, 32'h0);
   endtask

   task automatic st(input int sz, input logic [19:0] a, input logic [31:0] d);
      op(1'b0, 1'b1, 1'b1, sz == 4, sz == 2, sz == 1, 1'b0, a, d);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'd0, 32'h0);
      ld(4, 1'b0, 20'd1008);
      checks++;
      if (dout_s !== 32'h0) begin errors++; $display("FAIL reset_load data_out=%h expected=%h", dout_s, 32'h0); end
      checks++;
      if (err_s !== 1'b0) begin errors++; $display("FAIL reset_err AddressError=%b expected=0", err_s); end
      // reset wins over a concurrent store
      op(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'd1008, 32'hffff_ffff);
      ld(4, 1'b0, 20'd1008);
      checks++;
      if (dout_s !== 32'h0) begin errors++; $display("FAIL reset_priority data_out=%h expected=%h", dout_s, 32'h0); end
   endtask

   task automatic test_word;
      st(4, 20'd1008, 32'h0000_0001);
      st(4, 20'd980, 32'h0000_00d4);
      ld(4, 1'b0, 20'd1008);
      checks++;
      if (dout_s !== 32'h0000_0001) begin errors++; $display("FAIL word_1008 data_out=%h expected=%h", dout_s, 32'h1); end
      ld(4, 1'b0, 20'd980);
      checks++;
      if (dout_s !== 32'h0000_00d4) begin errors++; $display("FAIL word_980 data_out=%h expected=%h", dout_s, 32'hd4); end
   endtask

   task automatic test_lanes;
      st(4, 20'd0, 32'h1234_5678);
      st(2, 20'd2, 32'h0000_ffff);
      st(1, 20'd1, 32'h0000_0080);
      ld(4, 1'b0, 20'd0);
      checks++;
      if (dout_s !== 32'hffff_8078) begin errors++; $display("FAIL lanes_word data_out=%h expected=%h", dout_s, 32'hffff_8078); end
      ld(1, 1'b0, 20'd1);
      checks++;
      if (dout_s !== 32'hffff_ff80) begin errors++; $display("FAIL lanes_byte_sext data_out=%h expected=%h", dout_s, 32'hffff_ff80); end
      ld(1, 1'b1, 20'd1);
      checks++;
      if (dout_s !== 32'h0000_0080) begin errors++; $display("FAIL lanes_byte_zext data_out=%h expected=%h", dout_s, 32'h80); end
      ld(2, 1'b0, 20'd2);
      checks++;
      if (dout_s !== 32'hffff_ffff) begin errors++; $display("FAIL lanes_half_sext data_out=%h expected=%h", dout_s, 32'hffff_ffff); end
      ld(2, 1'b1, 20'd2);
      checks++;
      if (dout_s !== 32'h0000_ffff) begin errors++; $display("FAIL lanes_half_zext data_out=%h expected=%h", dout_s, 32'hffff); end
   endtask

   task automatic test_misaligned;
      st(4, 20'd2, 32'hdead_beef);
      checks++;
      if (err_s !== 1'b1) begin errors++; $display("FAIL misal_store_err AddressError=%b expected=1", err_s); end
      st(2, 20'd1, 32'h0000_1111);
      checks++;
      if (err_s !== 1'b1) begin errors++; $display("FAIL misal_half_err AddressError=%b expected=1", err_s); end
      ld(4, 1'b0, 20'd0);
      checks++;
      if (dout_s !== 32'hffff_8078) begin errors++; $display("FAIL misal_unchanged data_out=%h expected=%h", dout_s, 32'hffff_8078); end
      ld(2, 1'b0, 20'd3);
      checks++;
      if (err_s !== 1'b1) begin errors++; $display("FAIL misal_load_err AddressError=%b expected=1", err_s); end
      checks++;
      if (dout_s !== 32'h0) begin errors++; $display("FAIL misal_load_data data_out=%h expected=%h", dout_s, 32'h0); end
   endtask

   task automatic test_range;
      ld(4, 1'b0, 20'd1024);
      checks++;
      if (err_s !== 1'b1) begin errors++; $display("FAIL range_err AddressError=%b expected=1", err_s); end
      checks++;
      if (dout_s !== 32'h0) begin errors++; $display("FAIL range_data data_out=%h expected=%h", dout_s, 32'h0); end
      // an out-of-range byte store must not wrap onto address 0
      st(1, 20'd1024, 32'h0000_0033);
      ld(1, 1'b1, 20'd0);
      checks++;
      if (dout_s !== 32'h0000_0078) begin errors++; $display("FAIL range_nowrap data_out=%h expected=%h", dout_s, 32'h78); end
      st(4, 20'd1020, 32'ha5a5_a5a5);
      checks++;
      if (err_s !== 1'b0) begin errors++; $display("FAIL range_top_err AddressError=%b expected=0", err_s); end
      ld(4, 1'b0, 20'd1020);
      checks++;
      if (dout_s !== 32'ha5a5_a5a5) begin errors++; $display("FAIL range_top data_out=%h expected=%h", dout_s, 32'ha5a5_a5a5); end
      ld(1, 1'b1, 20'd1023);
      checks++;
      if (dout_s !== 32'h0000_00a5) begin errors++; $display("FAIL range_top_byte data_out=%h expected=%h", dout_s, 32'ha5); end
   endtask

   task automatic test_idle;
      op(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'd980, 32'h0);
      checks++;
      if (err_s !== 1'b0) begin errors++; $display("FAIL idle_err AddressError=%b expected=0", err_s); end
      checks++;
      if (dout_s !== 32'h0) begin errors++; $display("FAIL idle_data data_out=%h expected=%h", dout_s, 32'h0); end
      op(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20'd2000, 32'h0);
      checks++;
      if (err_s !== 1'b0) begin errors++; $display("FAIL idle_range_err AddressError=%b expected=0", err_s); end
      ld(4, 1'b0, 20'd980);
      checks++;
      if (dout_s !== 32'h0000_00d4) begin errors++; $display("FAIL idle_nowrite data_out=%h expected=%h", dout_s, 32'hd4); end
   endtask

   task automatic test_random;
      logic        en, we, iw, ih, ib, iz;
      logic [19:0] a;
      logic [31:0] d, exp_d;
      logic        exp_e;
      int          sz, sel;
      for (int n = 0; n < 400; n++) begin
         en  = ($urandom_range(0, 9) != 0);
         we  = $urandom_range(0, 1) == 1;
         iw  = $urandom_range(0, 3) == 0;
         ih  = $urandom_range(0, 2) == 0;
         ib  = $urandom_range(0, 1) == 1;
         iz  = $urandom_range(0, 1) == 1;
         d   = $urandom;
         sel = $urandom_range(0, 19);
         if (sel == 0)      a = 20'($urandom_range(1024, 20'hfffff));
         else if (sel < 10) a = 20'($urandom_range(0, 63));
         else               a = 20'($urandom_range(960, 1023));
         sz    = model_size(iw, ih, ib);
         exp_e = model_err(en, sz, a);
         exp_d = (en && !we && !exp_e) ? model_load(sz, a, iz) : 32'h0;
         op(1'b0, en, we, iw, ih, ib, iz, a, d);
         checks++;
         if (err_s !== exp_e) begin
            errors++;
            $display("FAIL rand_err n=%0d addr=%0d AddressError=%b expected=%b", n, a, err_s, exp_e);
         end
         checks++;
         if (dout_s !== exp_d) begin
            errors++;
            $display("FAIL rand_data n=%0d addr=%0d data_out=%h expected=%h", n, a, dout_s, exp_d);
         end
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_lanes();
      test_misaligned();
      test_range();
      test_idle();
      test_random();
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
